// File: rtl/fetch_pkg.sv
// Shared fetch-side types: instruction width, buffer entry layout and the
// instruction-buffer FSM state encoding.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            exc;
  } ibuff_entry_t;

  typedef enum logic {
    IBUFF_RUN  = 1'b0,
    IBUFF_HOLD = 1'b1
  } ibuff_state_t;

endpackage

// File: rtl/fetch_ibuff_if.sv
// f2 -> ibuff -> decode handshake bundle. Both sides use valid/ready: a word
// moves on a rising edge only when its valid and the receiver's ready are high.
interface fetch_ibuff_if #(
    parameter int DEPTH = 8
);
    logic                        f2_valid;
    logic [fetch_pkg::XLEN-1:0]  f2_instr;
    logic [fetch_pkg::XLEN-1:0]  f2_pc;
    logic                        f2_exc;
    logic                        ibuff_ready;
    logic                        flush;
    logic                        dec_valid;
    logic [fetch_pkg::XLEN-1:0]  dec_instr;
    logic [fetch_pkg::XLEN-1:0]  dec_pc;
    logic                        dec_exc;
    logic                        dec_ready;
    logic [$clog2(DEPTH):0]      ibuff_count;

    modport master (
        output f2_valid, f2_instr, f2_pc, f2_exc, flush, dec_ready,
        input  ibuff_ready, dec_valid, dec_instr, dec_pc, dec_exc, ibuff_count
    );

    modport slave (
        input  f2_valid, f2_instr, f2_pc, f2_exc, flush, dec_ready,
        output ibuff_ready, dec_valid, dec_instr, dec_pc, dec_exc, ibuff_count
    );
endinterface

// File: rtl/fetch_ibuff_mem.sv
// ibuff_mem: DEPTH x entry register array, synchronous write, asynchronous
// read, cleared to zero by the active-low asynchronous reset.
module ibuff_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  ibuff_entry_t             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output ibuff_entry_t             o_rdata
);
    ibuff_entry_t r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fetch_ibuff.sv
// fetch_ibuff: circular instruction buffer between f2 and decode with an
// exception hold state. Define IBUFF_BYPASS_EN for empty-buffer f2->decode forwarding.
module fetch_ibuff
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ibuff_if.slave  bus,
    output ibuff_state_t  o_dbg_state
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    ibuff_state_t  r_state, w_state_nxt;
    ibuff_entry_t  w_wr_entry, w_rd_entry;
    logic          w_hold, w_ready, w_stored_valid, w_bypass, w_enq, w_deq;

    assign w_hold         = (r_state == IBUFF_HOLD);
    assign w_ready        = (r_count != FULL_CNT) && !w_hold && !bus.flush;
    assign w_stored_valid = (r_count != '0) && !bus.flush;

`ifdef IBUFF_BYPASS_EN
    assign w_bypass = (r_count == '0) && bus.f2_valid && bus.dec_ready && !w_hold && !bus.flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word goes straight to decode and never touches storage.
    assign w_enq = bus.f2_valid && w_ready && !w_bypass;
    assign w_deq = w_stored_valid && bus.dec_ready;

    assign w_wr_entry = '{instr: bus.f2_instr, pc: bus.f2_pc, exc: bus.f2_exc};

    ibuff_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = IBUFF_RUN;
        end else if (r_state == IBUFF_RUN && (w_enq || w_bypass) && bus.f2_exc) begin
            w_state_nxt = IBUFF_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IBUFF_RUN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
                else if (w_deq && !w_enq) r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        bus.dec_valid = w_stored_valid || w_bypass;
        bus.dec_instr = w_rd_entry.instr;
        bus.dec_pc    = w_rd_entry.pc;
        bus.dec_exc   = w_rd_entry.exc;
        if (w_bypass) begin
            bus.dec_instr = bus.f2_instr;
            bus.dec_pc    = bus.f2_pc;
            bus.dec_exc   = bus.f2_exc;
        end
    end

    assign bus.ibuff_ready = w_ready;
    assign bus.ibuff_count = r_count;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_fetch_ibuff.sv
// Self-checking bench for fetch_ibuff: directed scenarios plus randomized
// traffic against a queue-based model of the buffer.
module tb_fetch_ibuff;
  import fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 2 * XLEN + 1;
`ifdef IBUFF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         rst;
  ibuff_state_t dbg_state;

  fetch_ibuff_if #(.DEPTH(DEPTH)) bus ();

  fetch_ibuff #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Model: entries packed as {instr, pc, exc}.
  logic [W-1:0] exp_q[$];
  bit           m_hold;
  int           n_checks;
  int           n_pass;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic exc,
                       input logic dr, input logic fl);
    bus.f2_valid  = v;
    bus.f2_instr  = $urandom();
    bus.f2_pc     = pc;
    bus.f2_exc    = exc;
    bus.dec_ready = dr;
    bus.flush     = fl;
  endtask

  // Advance one rising edge and apply the same transfer to the model.
  task automatic tick();
    bit byp, enq, deq;
    @(posedge clk);
    if (bus.flush) begin
      exp_q.delete();
      m_hold = 1'b0;
    end else begin
      byp = BYP && exp_q.size() == 0 && bus.f2_valid && bus.dec_ready && !m_hold;
      deq = exp_q.size() != 0 && bus.dec_ready;
      enq = bus.f2_valid && exp_q.size() < DEPTH && !m_hold && !byp;
      if (deq) void'(exp_q.pop_front());
      if (enq) exp_q.push_back({bus.f2_instr, bus.f2_pc, bus.f2_exc});
      if ((enq || byp) && bus.f2_exc) m_hold = 1'b1;
    end
    #1;
  endtask

  task automatic fill(input int n, input logic [XLEN-1:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    n_checks++; if (bus.dec_valid !== 1'b0) $display("FAIL rst_dec_valid got=%b exp=0", bus.dec_valid); else n_pass++;
    n_checks++; if (bus.dec_instr !== '0) $display("FAIL rst_dec_instr got=%h exp=0", bus.dec_instr); else n_pass++;
    n_checks++; if (bus.dec_pc !== '0) $display("FAIL rst_dec_pc got=%h exp=0", bus.dec_pc); else n_pass++;
    n_checks++; if (bus.dec_exc !== 1'b0) $display("FAIL rst_dec_exc got=%b exp=0", bus.dec_exc); else n_pass++;
    n_checks++; if (bus.ibuff_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", bus.ibuff_ready); else n_pass++;
    n_checks++; if (bus.ibuff_count !== 4'd0) $display("FAIL rst_count got=%0d exp=0", bus.ibuff_count); else n_pass++;
    exp_q.delete();
    m_hold = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    fill(8, 32'h1000);
    #2;
    n_checks++; if (bus.ibuff_ready !== 1'b0) $display("FAIL fill_ready got=%b exp=0", bus.ibuff_ready); else n_pass++;
    n_checks++; if (bus.ibuff_count !== 4'd8) $display("FAIL fill_count got=%0d exp=8", bus.ibuff_count); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      #2;
      n_checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h1000 + 32'(4 * i))
        $display("FAIL drain_pc got=%b/%h exp=1/%h", bus.dec_valid, bus.dec_pc, 32'h1000 + 32'(4 * i)); else n_pass++;
      n_checks++; if (bus.dec_instr !== exp_q[0][W-1 -: XLEN])
        $display("FAIL drain_instr got=%h exp=%h", bus.dec_instr, exp_q[0][W-1 -: XLEN]); else n_pass++;
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++; if (bus.dec_valid !== 1'b0) $display("FAIL drain_empty_valid got=%b exp=0", bus.dec_valid); else n_pass++;
    n_checks++; if (bus.ibuff_count !== 4'd0) $display("FAIL drain_empty_count got=%0d exp=0", bus.ibuff_count); else n_pass++;
    tick();
  endtask

  task automatic test_streaming();
    logic [XLEN-1:0] e_pc;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
      #2;
      if (i > 0 || BYP) begin
        e_pc = BYP ? 32'h4000 + 32'(4 * i) : 32'h4000 + 32'(4 * (i - 1));
        n_checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== e_pc)
          $display("FAIL stream_pc got=%b/%h exp=1/%h", bus.dec_valid, bus.dec_pc, e_pc); else n_pass++;
        n_checks++; if (bus.ibuff_count !== (BYP ? 4'd0 : 4'd1))
          $display("FAIL stream_count got=%0d exp=%0d", bus.ibuff_count, BYP ? 0 : 1); else n_pass++;
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++; if (bus.ibuff_count !== 4'd0) $display("FAIL stream_end_count got=%0d exp=0", bus.ibuff_count); else n_pass++;
    tick();
  endtask

  task automatic test_full_dequeue();
    fill(8, 32'h5000);
    drive(1'b1, 32'h5020, 1'b0, 1'b1, 1'b0);
    #2;
    n_checks++; if (bus.ibuff_ready !== 1'b0) $display("FAIL fulldq_ready got=%b exp=0", bus.ibuff_ready); else n_pass++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++; if (bus.ibuff_count !== 4'd7) $display("FAIL fulldq_count got=%0d exp=7", bus.ibuff_count); else n_pass++;
    n_checks++; if (bus.ibuff_ready !== 1'b1) $display("FAIL fulldq_ready_next got=%b exp=1", bus.ibuff_ready); else n_pass++;
    n_checks++; if (bus.dec_pc !== 32'h5004) $display("FAIL fulldq_head got=%h exp=00005004", bus.dec_pc); else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_exc_hold();
    drive(1'b1, 32'h2000, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h2004, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h2008, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++; if (bus.ibuff_ready !== 1'b0) $display("FAIL hold_ready got=%b exp=0", bus.ibuff_ready); else n_pass++;
    n_checks++; if (dbg_state !== IBUFF_HOLD) $display("FAIL hold_state got=%b exp=1", dbg_state); else n_pass++;
    tick();
    drive(1'b1, 32'h2008, 1'b0, 1'b1, 1'b0);
    #2;
    n_checks++; if (bus.ibuff_count !== 4'd2) $display("FAIL hold_count got=%0d exp=2", bus.ibuff_count); else n_pass++;
    n_checks++; if (bus.dec_pc !== 32'h2000 || bus.dec_exc !== 1'b0)
      $display("FAIL hold_head0 got=%h/%b exp=00002000/0", bus.dec_pc, bus.dec_exc); else n_pass++;
    tick();
    #2;
    n_checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h2004 || bus.dec_exc !== 1'b1)
      $display("FAIL hold_head1 got=%b/%h/%b exp=1/00002004/1", bus.dec_valid, bus.dec_pc, bus.dec_exc); else n_pass++;
    tick();
    #2;
    n_checks++; if (bus.dec_valid !== 1'b0 || bus.ibuff_ready !== 1'b0)
      $display("FAIL hold_drained got=%b/%b exp=0/0", bus.dec_valid, bus.ibuff_ready); else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++; if (bus.ibuff_ready !== 1'b1 || bus.ibuff_count !== 4'd0)
      $display("FAIL hold_flush got=%b/%0d exp=1/0", bus.ibuff_ready, bus.ibuff_count); else n_pass++;
    tick();
  endtask

  task automatic test_flush_collision();
    fill(3, 32'h6000);
    drive(1'b1, 32'h600C, 1'b0, 1'b1, 1'b1);
    #2;
    n_checks++; if (bus.dec_valid !== 1'b0 || bus.ibuff_ready !== 1'b0)
      $display("FAIL coll_flush_cycle got=%b/%b exp=0/0", bus.dec_valid, bus.ibuff_ready); else n_pass++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++; if (bus.ibuff_count !== 4'd0 || bus.dec_valid !== 1'b0 || bus.ibuff_ready !== 1'b1)
      $display("FAIL coll_after got=%0d/%b/%b exp=0/0/1", bus.ibuff_count, bus.dec_valid, bus.ibuff_ready); else n_pass++;
    drive(1'b1, 32'h7000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++; if (bus.dec_pc !== 32'h7000 || bus.ibuff_count !== 4'd1)
      $display("FAIL coll_next_enq got=%h/%0d exp=00007000/1", bus.dec_pc, bus.ibuff_count); else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_async_reset();
    fill(5, 32'h8000);
    #2;
    n_checks++; if (bus.ibuff_count !== 4'd5) $display("FAIL areset_pre got=%0d exp=5", bus.ibuff_count); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.dec_valid !== 1'b0 || bus.ibuff_count !== 4'd0)
      $display("FAIL areset_now got=%b/%0d exp=0/0", bus.dec_valid, bus.ibuff_count); else n_pass++;
    exp_q.delete();
    m_hold = 1'b0;
    #1;
    rst = 1'b1;
    tick();
  endtask

`ifdef IBUFF_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 32'h3000, 1'b0, 1'b1, 1'b0);
    #2;
    n_checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h3000)
      $display("FAIL bypass_fwd got=%b/%h exp=1/00003000", bus.dec_valid, bus.dec_pc); else n_pass++;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    n_checks++; if (bus.ibuff_count !== 4'd0) $display("FAIL bypass_count got=%0d exp=0", bus.ibuff_count); else n_pass++;
    tick();
  endtask
`endif

  task automatic test_random();
    bit           v, exc, dr, fl, byp, e_valid, e_ready;
    logic [W-1:0] e_head;
    for (int c = 0; c < 400; c++) begin
      v   = $urandom_range(0, 3) != 0;
      exc = $urandom_range(0, 15) == 0;
      dr  = $urandom_range(0, 2) != 0;
      fl  = m_hold ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 39) == 0);
      drive(v, $urandom(), exc, dr, fl);
      #2;
      byp     = BYP && exp_q.size() == 0 && v && dr && !m_hold && !fl;
      e_valid = (exp_q.size() != 0 || byp) && !fl;
      e_ready = exp_q.size() < DEPTH && !m_hold && !fl;
      e_head  = byp ? {bus.f2_instr, bus.f2_pc, bus.f2_exc} : (exp_q.size() != 0 ? exp_q[0] : '0);
      n_checks++; if (bus.dec_valid !== e_valid) $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.dec_valid, e_valid); else n_pass++;
      n_checks++; if (bus.ibuff_ready !== e_ready) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.ibuff_ready, e_ready); else n_pass++;
      n_checks++; if (bus.ibuff_count !== 4'(exp_q.size()))
        $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.ibuff_count, exp_q.size()); else n_pass++;
      n_checks++; if (dbg_state !== (m_hold ? IBUFF_HOLD : IBUFF_RUN))
        $display("FAIL rnd_state c=%0d got=%b exp=%b", c, dbg_state, m_hold); else n_pass++;
      if (e_valid) begin
        n_checks++; if ({bus.dec_instr, bus.dec_pc, bus.dec_exc} !== e_head)
          $display("FAIL rnd_head c=%0d got=%h exp=%h", c, {bus.dec_instr, bus.dec_pc, bus.dec_exc}, e_head); else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_hold   = 1'b0;
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_dequeue();
    test_exc_hold();
    test_flush_collision();
    test_async_reset();
`ifdef IBUFF_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_ibuff.md
# fetch_ibuff

Instruction buffer between fetch stage 2 and decode. Accepts one fetched instruction word per cycle (with its PC and exception flag) from f2, buffers up to DEPTH entries in a circular FIFO, and presents them in order to decode over a valid/ready handshake. Back-pressures f2 when full or when an exception entry is held. Drops all contents on a pipeline flush or redirect.

## Interface
- DEPTH, 8: entries; power of two, ≥2
- XLEN, 32: instruction and PC width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- f2_valid  in  1  f2 presents an instruction this cycle
- f2_instr  in  XLEN  instruction word (the f2 IBuff_out word)
- f2_pc  in  XLEN  virtual PC of f2_instr
- f2_exc  in  1  fetch exception attached to this word
- ibuff_ready  out  1  buffer accepts an f2 word this cycle
- flush  in  1  redirect/flush; discards all buffered entries
- dec_valid  out  1  head entry valid for decode
- dec_instr  out  XLEN  head instruction
- dec_pc  out  XLEN  head PC
- dec_exc  out  1  head exception flag
- dec_ready  in  1  decode consumes the head this cycle
- ibuff_count  out  log2(DEPTH)+1  current occupancy

## Operation
- Enqueue: f2_valid && ibuff_ready && !flush; writes {instr, pc, exc} at wr_ptr, wr_ptr++.
- Dequeue: dec_valid && dec_ready; rd_ptr++.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH. Occupancy is a separate counter: +1 on enqueue only, −1 on dequeue only, unchanged on both.
- ibuff_ready = (count < DEPTH) && !hold && !flush. Does not look ahead to a same-cycle dequeue: when full, no enqueue occurs even if decode dequeues.
- dec_valid = (count != 0) && !flush; dec_* driven from mem[rd_ptr].
- State machine, 2 states:
  - RUN: normal. An enqueue with f2_exc=1 moves to HOLD.
  - HOLD: ibuff_ready=0. Buffered entries, including the exception entry, still drain to decode. Leaves only on flush, to RUN.
- Flush has priority over everything in the same cycle. Enqueue and dequeue are suppressed. Next edge: wr_ptr=rd_ptr=0, count=0, state=RUN.
- Simultaneous enqueue and dequeue on an empty buffer is impossible, because dec_valid=0 when empty. The bypass option below is the exception.

## Timing
- Reset values (while rst=0): wr_ptr=0, rd_ptr=0, count=0, state=RUN, storage all-zero.
  - Outputs during reset: dec_valid=0, dec_instr=0, dec_pc=0, dec_exc=0, ibuff_ready=1, ibuff_count=0.
- Reset mid-operation discards all entries immediately (asynchronous).
- Latency: word enqueued at edge N is visible with dec_valid=1 in cycle N+1.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained.
- Full: count==DEPTH, so ibuff_ready=0 that cycle. It returns to 1 in the cycle after the first dequeue.
- Flush cycle: dec_valid=0 and ibuff_ready=0 combinationally. In the cycle after, dec_valid=0 and ibuff_ready=1.
- dec_* are don't-care whenever dec_valid=0.

## Configuration
- IBUFF_BYPASS_EN defined:
  - Condition: count==0 && f2_valid && dec_ready && !hold && !flush.
  - Behaviour: f2_* is forwarded combinationally to dec_* with dec_valid=1, giving 0-cycle latency.
  - Storage, pointers and count are not written.
  - If f2_exc=1, the state still moves to HOLD.
- IBUFF_BYPASS_EN undefined: no forwarding. dec_* always come from storage, with 1-cycle minimum latency.

## Structure
- Shared package fetch_pkg:
  - XLEN
  - ibuff_entry_t {instr[XLEN], pc[XLEN], exc}
  - state encoding constants IBUFF_RUN / IBUFF_HOLD
- One sub-module, ibuff_mem: DEPTH×entry 1-write/1-read register array.
  - Synchronous write, asynchronous read.
  - Async active-low reset to zero.
- fetch_ibuff holds the pointers, count, FSM and handshake logic.

## Test plan
- Fill/drain: DEPTH=8, dec_ready=0, 8 writes with PC 0x1000..0x101C.
  - Expect ibuff_ready=0 and ibuff_count=8.
  - Then dec_ready=1 → 8 entries in PC order, dec_valid drops after 0x101C, ibuff_count=0.
- Streaming: f2_valid=1 and dec_ready=1 for 20 cycles → one entry per cycle, count stays 1, pointers wrap without loss or duplication.
- Full with dequeue: count=8, f2_valid=1, dec_ready=1 → no enqueue that cycle, count=7, ibuff_ready=1 next cycle.
- Exception hold: enqueue 0x2000, 0x2004 with f2_exc=1, then 0x2008.
  - Expect 0x2008 refused (ibuff_ready=0).
  - Decode receives 0x2000, then 0x2004 with dec_exc=1.
  - Then flush → ibuff_ready=1, count=0.
- Flush collision: count=3, with flush, f2_valid and dec_ready all high → dec_valid=0 that cycle, count=0 next cycle, nothing written.
- Async reset mid-stream: rst low between edges with count=5 → dec_valid=0 and count=0 immediately.
  - With IBUFF_BYPASS_EN: empty buffer, f2_valid=1, f2_pc=0x3000, dec_ready=1 → dec_valid=1, dec_pc=0x3000 in the same cycle, count stays 0.
